ecat_sync_gen: RTL and testbench

ECAT_SYNC_GEN -- requirements
Module: ecat_sync_gen

---
 rtl/ecat_sync_pkg.sv | 28 ++
 rtl/ecat_sync_cfg_check.sv | 25 ++
 rtl/ecat_sync_gen.sv | 160 ++++++++++++++++
 tb/tb_ecat_sync_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecat_sync_pkg.sv
// Shared types and constants for the SYNC0-style pulse generator.
// Drift fields in the config struct exist only with ECAT_SYNC_DRIFT_EN defined.
package ecat_sync_pkg;

   localparam int unsigned MIN_CYCLE_TICKS = 2;
   localparam int unsigned TIME_W          = 64;
   localparam int unsigned MAX_PERIOD_W    = 64;
   localparam int unsigned WIDTH_W         = 16;
   localparam int unsigned DRIFT_W         = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } ecat_sync_state_t;

   // Period is held zero-extended to the widest supported PERIOD_W.
   typedef struct packed {
      logic [TIME_W-1:0]       start_time;
      logic [MAX_PERIOD_W-1:0] cycle_ticks;
      logic [WIDTH_W-1:0]      pulse_width;
`ifdef ECAT_SYNC_DRIFT_EN
      logic [DRIFT_W-1:0]      drift_interval;
      logic                    drift_dir;
`endif
   } ecat_sync_cfg_t;

endpackage

// File: rtl/ecat_sync_cfg_check.sv
// Combinational validation of a candidate sync configuration.
// With ECAT_SYNC_DRIFT_EN, a shortening drift must still leave a low phase.
module ecat_sync_cfg_check
   import ecat_sync_pkg::*;
(
   input  ecat_sync_cfg_t cfg,
   output logic           valid_c
);

   logic [MAX_PERIOD_W-1:0] width_ext;

   assign width_ext = MAX_PERIOD_W'(cfg.pulse_width);

   always_comb begin
      valid_c = 1'b1;
      if (cfg.cycle_ticks < MAX_PERIOD_W'(MIN_CYCLE_TICKS)) valid_c = 1'b0;
      if (cfg.pulse_width == '0)                           valid_c = 1'b0;
      if (width_ext >= cfg.cycle_ticks)                    valid_c = 1'b0;
`ifdef ECAT_SYNC_DRIFT_EN
      if (cfg.drift_dir && (width_ext >= cfg.cycle_ticks - MAX_PERIOD_W'(1)))
         valid_c = 1'b0;
`endif
   end

endmodule

// File: rtl/ecat_sync_gen.sv
// SYNC0-style pulse train generator locked to a free-running tick counter.
// Optional periodic period stretch/shrink is enabled by ECAT_SYNC_DRIFT_EN.
module ecat_sync_gen
   import ecat_sync_pkg::*;
#(
   parameter int unsigned PERIOD_W = 32
)
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                UPDATE,
   input  logic [TIME_W-1:0]   START_TIME,
   input  logic [PERIOD_W-1:0] CYCLE_TICKS,
   input  logic [WIDTH_W-1:0]  PULSE_WIDTH,
   input  logic                STOP,
`ifdef ECAT_SYNC_DRIFT_EN
   input  logic [DRIFT_W-1:0]  DRIFT_INTERVAL,
   input  logic [0:0]          DRIFT_DIR,
`endif
   output logic [TIME_W-1:0]   LOCAL_TIME,
   output logic                ECAT_SYNC,
   output logic [PERIOD_W-1:0] SYNC_COUNT,
   output logic                CFG_ERR,
   output logic                LATE
);

   ecat_sync_state_t        state, state_nx;
   ecat_sync_cfg_t          cfg_in, cfg_q, cfg_nx;
   logic                    cfg_valid_c;
   logic                    accept, reject, trigger;
   logic [PERIOD_W-1:0]     phase_q, phase_nx;
   logic [MAX_PERIOD_W-1:0] last_phase;
   logic                    sync_nx, cfg_err_nx, late_nx;
   logic [PERIOD_W-1:0]     count_nx;
`ifdef ECAT_SYNC_DRIFT_EN
   logic [DRIFT_W-1:0]      drift_cnt_q, drift_cnt_nx;
   logic                    drift_period;
`endif

   always_comb begin
      cfg_in             = '0;
      cfg_in.start_time  = START_TIME;
      cfg_in.cycle_ticks = MAX_PERIOD_W'(CYCLE_TICKS);
      cfg_in.pulse_width = PULSE_WIDTH;
`ifdef ECAT_SYNC_DRIFT_EN
      cfg_in.drift_interval = DRIFT_INTERVAL;
      cfg_in.drift_dir      = DRIFT_DIR;
`endif
   end

   ecat_sync_cfg_check u_cfg_check (
      .cfg     (cfg_in),
      .valid_c (cfg_valid_c)
   );

   // STOP discards any UPDATE presented in the same cycle.
   assign accept  = UPDATE && !STOP && cfg_valid_c;
   assign reject  = UPDATE && !STOP && !cfg_valid_c;
   assign trigger = (state == ARMED) && ((LOCAL_TIME == cfg_q.start_time) || LATE);

`ifdef ECAT_SYNC_DRIFT_EN
   assign drift_period = (cfg_q.drift_interval != '0) &&
                         (drift_cnt_q == cfg_q.drift_interval - DRIFT_W'(1));
   always_comb begin
      last_phase = cfg_q.cycle_ticks - MAX_PERIOD_W'(1);
      if (drift_period)
         last_phase = cfg_q.drift_dir ? cfg_q.cycle_ticks - MAX_PERIOD_W'(2) : cfg_q.cycle_ticks;
   end
`else
   assign last_phase = cfg_q.cycle_ticks - MAX_PERIOD_W'(1);
`endif

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (STOP)        state_nx = IDLE;
      else if (accept) state_nx = ARMED;
      else if (trigger) state_nx = RUN;
   end

   always_comb begin
      cfg_nx     = cfg_q;
      phase_nx   = phase_q;
      sync_nx    = ECAT_SYNC;
      count_nx   = SYNC_COUNT;
      cfg_err_nx = CFG_ERR;
      late_nx    = LATE;
`ifdef ECAT_SYNC_DRIFT_EN
      drift_cnt_nx = drift_cnt_q;
`endif
      if (STOP) begin
         sync_nx = 1'b0;
      end else if (accept) begin
         cfg_nx     = cfg_in;
         phase_nx   = '0;
         sync_nx    = 1'b0;
         count_nx   = '0;
         cfg_err_nx = 1'b0;
         late_nx    = (START_TIME <= LOCAL_TIME);
      end else begin
         if (reject) cfg_err_nx = 1'b1;
         case (state)
            ARMED: begin
               if (trigger) begin
                  phase_nx = '0;
                  sync_nx  = 1'b1;
                  count_nx = SYNC_COUNT + PERIOD_W'(1);
`ifdef ECAT_SYNC_DRIFT_EN
                  drift_cnt_nx = '0;
`endif
               end
            end
            RUN: begin
               if (MAX_PERIOD_W'(phase_q) == last_phase) begin
                  phase_nx = '0;
`ifdef ECAT_SYNC_DRIFT_EN
                  drift_cnt_nx = drift_period ? '0 : drift_cnt_q + DRIFT_W'(1);
`endif
               end else begin
                  phase_nx = phase_q + PERIOD_W'(1);
               end
               sync_nx = MAX_PERIOD_W'(phase_nx) < MAX_PERIOD_W'(cfg_q.pulse_width);
               if (sync_nx && !ECAT_SYNC) count_nx = SYNC_COUNT + PERIOD_W'(1);
            end
            default: sync_nx = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         LOCAL_TIME <= '0;
         cfg_q      <= '0;
         phase_q    <= '0;
         ECAT_SYNC  <= 1'b0;
         SYNC_COUNT <= '0;
         CFG_ERR    <= 1'b0;
         LATE       <= 1'b0;
`ifdef ECAT_SYNC_DRIFT_EN
         drift_cnt_q <= '0;
`endif
      end else begin
         LOCAL_TIME <= LOCAL_TIME + TIME_W'(1);
         cfg_q      <= cfg_nx;
         phase_q    <= phase_nx;
         ECAT_SYNC  <= sync_nx;
         SYNC_COUNT <= count_nx;
         CFG_ERR    <= cfg_err_nx;
         LATE       <= late_nx;
`ifdef ECAT_SYNC_DRIFT_EN
         drift_cnt_q <= drift_cnt_nx;
`endif
      end
   end

endmodule

// File: tb/tb_ecat_sync_gen.sv
// Directed self-checking bench for ecat_sync_gen (drift test only with ECAT_SYNC_DRIFT_EN).
module tb_ecat_sync_gen;

   localparam int unsigned PW = 32;

   logic          CLK = 1'b0;
   logic          RST, UPDATE, STOP;
   logic [63:0]   START_TIME;
   logic [PW-1:0] CYCLE_TICKS;
   logic [15:0]   PULSE_WIDTH;
   logic [63:0]   LOCAL_TIME;
   logic          ECAT_SYNC;
   logic [PW-1:0] SYNC_COUNT;
   logic          CFG_ERR, LATE;
`ifdef ECAT_SYNC_DRIFT_EN
   logic [15:0]   DRIFT_INTERVAL;
   logic [0:0]    DRIFT_DIR;
`endif

   int total = 0;
   int bad   = 0;
   longint unsigned rise_q[$];
   int              hlen_q[$];
   logic            prev = 1'b0;
   int              hcnt = 0;

   always #5 CLK = ~CLK;

   ecat_sync_gen #(.PERIOD_W(PW)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .UPDATE         (UPDATE),
      .START_TIME     (START_TIME),
      .CYCLE_TICKS    (CYCLE_TICKS),
      .PULSE_WIDTH    (PULSE_WIDTH),
      .STOP           (STOP),
`ifdef ECAT_SYNC_DRIFT_EN
      .DRIFT_INTERVAL (DRIFT_INTERVAL),
      .DRIFT_DIR      (DRIFT_DIR),
`endif
      .LOCAL_TIME     (LOCAL_TIME),
      .ECAT_SYNC      (ECAT_SYNC),
      .SYNC_COUNT     (SYNC_COUNT),
      .CFG_ERR        (CFG_ERR),
      .LATE           (LATE)
   );

   // Records pre-increment LOCAL_TIME of each rising edge and each high-pulse length.
   always @(negedge CLK) begin
      if (RST) begin
         prev = 1'b0;
         hcnt = 0;
      end else begin
         if (ECAT_SYNC && !prev) rise_q.push_back(LOCAL_TIME - 64'd1);
         if (ECAT_SYNC) hcnt++;
         else if (prev) begin
            hlen_q.push_back(hcnt);
            hcnt = 0;
         end
         prev = ECAT_SYNC;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_lt(input longint unsigned t);
      int n = 0;
      while (LOCAL_TIME != t && n < 3000) begin
         step();
         n++;
      end
      total++;
      if (LOCAL_TIME != t) begin
         bad++;
         $display("FAIL wait_lt: LOCAL_TIME=%0d want %0d", LOCAL_TIME, t);
      end
   endtask

   // Present settings for one cycle, then scramble them to show they are ignored.
   task automatic do_update(input longint unsigned st, input int unsigned cyc, input int unsigned w);
      UPDATE      = 1'b1;
      START_TIME  = st;
      CYCLE_TICKS = PW'(cyc);
      PULSE_WIDTH = 16'(w);
      step();
      UPDATE      = 1'b0;
      START_TIME  = '1;
      CYCLE_TICKS = PW'(3);
      PULSE_WIDTH = 16'd1;
   endtask

   task automatic clear_mon();
      rise_q.delete();
      hlen_q.delete();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      total += 5;
      if (LOCAL_TIME !== 64'd0) begin bad++; $display("FAIL rst_time: got %0d want 0", LOCAL_TIME); end
      if (ECAT_SYNC !== 1'b0)   begin bad++; $display("FAIL rst_sync: got %0b want 0", ECAT_SYNC); end
      if (SYNC_COUNT !== '0)    begin bad++; $display("FAIL rst_count: got %0d want 0", SYNC_COUNT); end
      if (CFG_ERR !== 1'b0)     begin bad++; $display("FAIL rst_cfgerr: got %0b want 0", CFG_ERR); end
      if (LATE !== 1'b0)        begin bad++; $display("FAIL rst_late: got %0b want 0", LATE); end
      RST = 1'b0;
      step();
      total++;
      if (LOCAL_TIME !== 64'd1) begin bad++; $display("FAIL time_inc: got %0d want 1", LOCAL_TIME); end
   endtask

   task automatic test_basic();
      longint unsigned exp_r[3] = '{100, 140, 180};
      wait_lt(5);
      clear_mon();
      do_update(100, 40, 8);
      total += 3;
      if (ECAT_SYNC !== 1'b0) begin bad++; $display("FAIL basic_armed_sync: got %0b want 0", ECAT_SYNC); end
      if (LATE !== 1'b0)      begin bad++; $display("FAIL basic_late: got %0b want 0", LATE); end
      if (CFG_ERR !== 1'b0)   begin bad++; $display("FAIL basic_cfgerr: got %0b want 0", CFG_ERR); end
      wait_lt(190);
      total++;
      if (rise_q.size() != 3 || hlen_q.size() != 3) begin
         bad++;
         $display("FAIL basic_edges: rises=%0d pulses=%0d want 3/3", rise_q.size(), hlen_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total += 2;
            if (rise_q[i] != exp_r[i]) begin bad++; $display("FAIL basic_rise%0d: got %0d want %0d", i, rise_q[i], exp_r[i]); end
            if (hlen_q[i] != 8) begin bad++; $display("FAIL basic_width%0d: got %0d want 8", i, hlen_q[i]); end
         end
      end
      total++;
      if (SYNC_COUNT !== PW'(3)) begin bad++; $display("FAIL basic_count: got %0d want 3", SYNC_COUNT); end
   endtask

   task automatic test_cfg_err();
      int unsigned bc[3] = '{10, 10, 1};
      int unsigned bw[3] = '{10, 0, 1};
      wait_lt(195);
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         do_update(0, bc[i], bw[i]);
         total++;
         if (CFG_ERR !== 1'b1) begin bad++; $display("FAIL cfg_reject%0d: CFG_ERR=%0b want 1", i, CFG_ERR); end
      end
      wait_lt(230);
      total += 3;
      if (rise_q.size() != 1 || rise_q[0] != 64'd220) begin
         bad++;
         $display("FAIL cfg_train: rises=%0d first=%0d want 1 at 220", rise_q.size(), rise_q.size() > 0 ? rise_q[0] : 0);
      end
      if (SYNC_COUNT !== PW'(4)) begin bad++; $display("FAIL cfg_count: got %0d want 4", SYNC_COUNT); end
      if (LATE !== 1'b0)         begin bad++; $display("FAIL cfg_late: got %0b want 0", LATE); end
   endtask

   task automatic test_late();
      wait_lt(500);
      clear_mon();
      do_update(200, 40, 39);
      total += 4;
      if (LATE !== 1'b1)       begin bad++; $display("FAIL late_flag: got %0b want 1", LATE); end
      if (CFG_ERR !== 1'b0)    begin bad++; $display("FAIL late_cfgerr: got %0b want 0", CFG_ERR); end
      if (SYNC_COUNT !== '0)   begin bad++; $display("FAIL late_count_clr: got %0d want 0", SYNC_COUNT); end
      if (ECAT_SYNC !== 1'b0)  begin bad++; $display("FAIL late_armed_sync: got %0b want 0", ECAT_SYNC); end
      step();
      total++;
      if (ECAT_SYNC !== 1'b1) begin bad++; $display("FAIL late_rise: got %0b want 1 at LOCAL_TIME 502", ECAT_SYNC); end
      wait_lt(545);
      total += 3;
      if (rise_q.size() != 2 || rise_q[0] != 64'd501 || rise_q[1] != 64'd541) begin
         bad++;
         $display("FAIL late_edges: rises=%0d want 501,541", rise_q.size());
      end
      if (hlen_q.size() < 1 || hlen_q[0] != 39) begin
         bad++;
         $display("FAIL late_width: pulses=%0d want first width 39", hlen_q.size());
      end
      if (SYNC_COUNT !== PW'(2)) begin bad++; $display("FAIL late_count: got %0d want 2", SYNC_COUNT); end
   endtask

   task automatic test_stop_update();
      wait_lt(560);
      total++;
      if (ECAT_SYNC !== 1'b1) begin bad++; $display("FAIL stop_pre_sync: got %0b want 1", ECAT_SYNC); end
      STOP = 1'b1;
      do_update(570, 20, 5);
      STOP = 1'b0;
      clear_mon();
      total += 4;
      if (ECAT_SYNC !== 1'b0)    begin bad++; $display("FAIL stop_sync: got %0b want 0", ECAT_SYNC); end
      if (SYNC_COUNT !== PW'(2)) begin bad++; $display("FAIL stop_count: got %0d want 2", SYNC_COUNT); end
      if (LATE !== 1'b1)         begin bad++; $display("FAIL stop_late: got %0b want 1", LATE); end
      if (CFG_ERR !== 1'b0)      begin bad++; $display("FAIL stop_cfgerr: got %0b want 0", CFG_ERR); end
      wait_lt(640);
      total += 2;
      if (rise_q.size() != 0)    begin bad++; $display("FAIL stop_idle: rises=%0d want 0", rise_q.size()); end
      if (SYNC_COUNT !== PW'(2)) begin bad++; $display("FAIL stop_count_kept: got %0d want 2", SYNC_COUNT); end
   endtask

   task automatic test_reset_mid_pulse();
      clear_mon();
      do_update(650, 20, 8);
      wait_lt(660);
      do_update(0, 5, 5);
      wait_lt(692);
      total += 4;
      if (ECAT_SYNC !== 1'b1)    begin bad++; $display("FAIL mid_sync: got %0b want 1", ECAT_SYNC); end
      if (SYNC_COUNT !== PW'(3)) begin bad++; $display("FAIL mid_count: got %0d want 3", SYNC_COUNT); end
      if (CFG_ERR !== 1'b1)      begin bad++; $display("FAIL mid_cfgerr: got %0b want 1", CFG_ERR); end
      if (rise_q.size() != 3 || rise_q[2] != 64'd690) begin
         bad++;
         $display("FAIL mid_edges: rises=%0d want 3 ending at 690", rise_q.size());
      end
      RST = 1'b1;
      do_update(2, 4, 1);
      RST = 1'b0;
      clear_mon();
      total += 5;
      if (LOCAL_TIME !== 64'd0) begin bad++; $display("FAIL mid_rst_time: got %0d want 0", LOCAL_TIME); end
      if (ECAT_SYNC !== 1'b0)   begin bad++; $display("FAIL mid_rst_sync: got %0b want 0", ECAT_SYNC); end
      if (SYNC_COUNT !== '0)    begin bad++; $display("FAIL mid_rst_count: got %0d want 0", SYNC_COUNT); end
      if (CFG_ERR !== 1'b0)     begin bad++; $display("FAIL mid_rst_cfgerr: got %0b want 0", CFG_ERR); end
      if (LATE !== 1'b0)        begin bad++; $display("FAIL mid_rst_late: got %0b want 0", LATE); end
      wait_lt(30);
      total++;
      if (rise_q.size() != 0) begin bad++; $display("FAIL mid_rst_idle: rises=%0d want 0", rise_q.size()); end
   endtask

`ifdef ECAT_SYNC_DRIFT_EN
   task automatic test_drift();
      longint unsigned exp_r[6] = '{100, 140, 180, 220, 261, 301};
      clear_mon();
      DRIFT_INTERVAL = 16'd4;
      DRIFT_DIR      = 1'b0;
      do_update(100, 40, 8);
      DRIFT_INTERVAL = 16'd0;
      wait_lt(310);
      total++;
      if (rise_q.size() != 6) begin
         bad++;
         $display("FAIL drift_edges: rises=%0d want 6", rise_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (rise_q[i] != exp_r[i]) begin bad++; $display("FAIL drift_rise%0d: got %0d want %0d", i, rise_q[i], exp_r[i]); end
         end
      end
   endtask
`endif

   initial begin
      RST         = 1'b1;
      UPDATE      = 1'b0;
      STOP        = 1'b0;
      START_TIME  = '0;
      CYCLE_TICKS = '0;
      PULSE_WIDTH = '0;
`ifdef ECAT_SYNC_DRIFT_EN
      DRIFT_INTERVAL = '0;
      DRIFT_DIR      = '0;
`endif
      test_reset();
      test_basic();
      test_cfg_err();
      test_late();
      test_stop_update();
      test_reset_mid_pulse();
`ifdef ECAT_SYNC_DRIFT_EN
      test_drift();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
